gem_trig_frame_tx: RTL
======================

Name: gem_trig_frame_tx

Overview:
- Parametrised multi-link trigger framer, successor to the single-link GEM fiber output data path.
- Takes per-link S-bit cluster payloads each bunch crossing and serialises each into FRAME_WORDS 32-bit words with 8b10b K-code control flags.
- Inserts a rotating or TTC-locked frame separator, with overflow and BC0 overrides. Runs a comma/resync state machine.
- Feeds the GTX/GTP transceiver wrappers, one lane per link. It contains no transceiver primitive itself.

Parameters:
- NLINKS, 4, number of output lanes, 1..8.
- FRAME_WORDS, 2, 32-bit words per BX frame, 2..4. The clock runs at FRAME_WORDS x 40 MHz.
- DATA_BITS, 56, payload bits per link per frame. Must equal 32*FRAME_WORDS-8; otherwise elaboration fails.
- SYNC_FRAMES, 16, comma frames sent after reset or resync.
- LTNCY_PERIOD, 256, frames between latency-trigger pulses. Power of 2.

Ports:
- TRG_CLK80 input 1: transmit fabric clock (TXUSRCLK2 domain).
- TRG_RST_N input 1: asynchronous active-low reset.
- GEM_DATA input NLINKS*DATA_BITS: payload, link i at [i*DATA_BITS +: DATA_BITS].
- GEM_OVERFLOW input NLINKS: per-link overflow flag, more than 8 clusters.
- BXN_COUNTER input 12: TTC bunch counter.
- BC0 input 1: TTC BC0 flag.
- SEP_MODE input 1: separator source. 0 = local rotation, 1 = BXN_COUNTER[1:0].
- TX_RESYNC input 1: single-cycle request to re-send the comma sequence.
- INJ_ERR input 1: error-inject pulse (optional feature only).
- ENA_TEST_PAT input 1: select test pattern (optional feature only).
- TX_DATA output NLINKS*32: per-lane transceiver data.
- TX_ISK output NLINKS*4: per-lane char-is-K.
- FRAME_STROBE output 1: high on word 0 of each DATA frame.
- LINK_READY output 1: high in the DATA state.
- LTNCY_TRIG output 1: latency-measurement pulse.

Behaviour:
- Reset values (async on TRG_RST_N low), all outputs registered:
  - TX_DATA = 32'h50BC50BC per lane; TX_ISK = 4'b0101.
  - FRAME_STROBE, LINK_READY, LTNCY_TRIG = 0.
  - Word counter wcnt = 0; frame counter = 0; separator counter = 0; state = SYNC.
- wcnt: counts 0..FRAME_WORDS-1 and wraps. It runs in every state, so frame boundaries never shift.
- State machine:
  - SYNC: every lane sends 50BC50BC / 0101 each cycle. Counts frames (wcnt wraps) up to SYNC_FRAMES. On the wrap of frame SYNC_FRAMES-1, moves to DATA; the first DATA word is word 0.
  - DATA: normal framing. TX_RESYNC sampled high in DATA goes to SYNC at the next wcnt==0 boundary, never mid-frame. The sync frame count restarts.
  - TX_RESYNC asserted while in SYNC restarts the sync frame count.
- Capture: on the cycle with wcnt==FRAME_WORDS-1, GEM_DATA, GEM_OVERFLOW, BC0 and BXN_COUNTER[1:0] are latched into a holding register.
- Word order out of the holding register (word k at output cycle wcnt==k):
  - k < FRAME_WORDS-1: payload[DATA_BITS-1-32k -: 32], ISK 0000.
  - Last word: {payload[23:0], sep}, ISK 0001.
- Latency: input latched at the end of frame n appears as word 0 one cycle later, at frame n+1.
- Separator per lane, priority high to low:
  - That lane's overflow latched → FC.
  - BC0 latched → 1C (K28.0).
  - Otherwise by rotation index 0..3 → BC, F7, FB, FD.
- Rotation index:
  - SEP_MODE=0: 2-bit local counter, increments once per frame in DATA, cleared entering DATA.
  - SEP_MODE=1: latched BXN[1:0].
- FRAME_STROBE: 1 when state is DATA and wcnt==0.
- LTNCY_TRIG: 1-cycle pulse on word 0 when the DATA frame counter mod LTNCY_PERIOD == 0. The frame counter clears on DATA entry, so the first DATA frame pulses.
- LINK_READY: follows state==DATA, registered.
- Reset mid-frame: all outputs return to reset values immediately. Release starts at wcnt=0 in SYNC.

Optional Feature:
- Macro: GEM_TRIG_FRAME_PRBS_EN.
- With the macro defined:
  - Each lane has a 31-bit LFSR, next = {s[29:0], s[30]^s[27]}, reset seed 31'd(i+1).
  - The LFSR steps once per DATA frame, at capture.
  - With ENA_TEST_PAT=1, the payload is {s, s}[DATA_BITS-1:0], the LFSR state replicated and truncated to DATA_BITS, replacing GEM_DATA.
  - An INJ_ERR pulse inverts payload bit 0 of the next captured frame only, on all lanes.
- Without the macro: no LFSR logic. ENA_TEST_PAT and INJ_ERR are ignored; the ports remain.

Test Plan:
1. Reset release, NLINKS=4, FRAME_WORDS=2 → 16 frames (32 cycles) of 50BC50BC/0101 on all lanes. LINK_READY rises with first word 0; FRAME_STROBE and LTNCY_TRIG pulse on that cycle.
2. GEM_DATA lane0 = 56'h0123456789ABCD, SEP_MODE=0, no overflow/BC0 → words 01234567/0000 then 89ABCDBC/0001. The next frame's separator is F7, then FB, FD, BC.
3. GEM_OVERFLOW=4'b0010 with BC0=1 in the same frame → lane1 separator FC; lanes 0, 2 and 3 separator 1C.
4. SEP_MODE=1, BXN_COUNTER=12'h7 → separator FD; BXN=12'h8 → BC.
5. TX_RESYNC pulsed at wcnt=1 → the current frame completes, then 16 comma frames, then DATA resumes with the rotation restarted at BC.
6. With GEM_TRIG_FRAME_PRBS_EN and ENA_TEST_PAT=1 → lane0 payloads in successive frames carry LFSR states 2, 4, 8. An INJ_ERR pulse flips bit 0 of exactly one frame.

Source files
------------

// File: rtl/gem_trig_frame_tx_if.sv
// gem_trig_frame_tx_if: payload/control inputs and per-lane transceiver outputs of the
// multi-link trigger framer. "master" drives the payload side, "slave" is the framer.
interface gem_trig_frame_tx_if #(
  parameter int unsigned NLINKS    = 4,
  parameter int unsigned DATA_BITS = 56
);
  logic [NLINKS*DATA_BITS-1:0] GEM_DATA;
  logic [NLINKS-1:0]           GEM_OVERFLOW;
  logic [11:0]                 BXN_COUNTER;
  logic                        BC0;
  logic                        SEP_MODE;
  logic                        TX_RESYNC;
  logic                        INJ_ERR;
  logic                        ENA_TEST_PAT;
  logic [NLINKS*32-1:0]        TX_DATA;
  logic [NLINKS*4-1:0]         TX_ISK;
  logic                        FRAME_STROBE;
  logic                        LINK_READY;
  logic                        LTNCY_TRIG;

  modport master (
    output GEM_DATA, GEM_OVERFLOW, BXN_COUNTER, BC0, SEP_MODE, TX_RESYNC, INJ_ERR,
           ENA_TEST_PAT,
    input  TX_DATA, TX_ISK, FRAME_STROBE, LINK_READY, LTNCY_TRIG
  );

  modport slave (
    input  GEM_DATA, GEM_OVERFLOW, BXN_COUNTER, BC0, SEP_MODE, TX_RESYNC, INJ_ERR,
           ENA_TEST_PAT,
    output TX_DATA, TX_ISK, FRAME_STROBE, LINK_READY, LTNCY_TRIG
  );
endinterface

// File: rtl/gem_trig_frame_tx.sv
// gem_trig_frame_tx: serialises per-link S-bit cluster payloads into FRAME_WORDS 32-bit
// words per bunch crossing, with K-code separator, comma/resync sequencing and latency
// trigger. One lane per link; no transceiver primitives here.
// Optional: define GEM_TRIG_FRAME_PRBS_EN for per-lane LFSR test pattern and error inject.
module gem_trig_frame_tx #(
  parameter int unsigned NLINKS       = 4,
  parameter int unsigned FRAME_WORDS  = 2,
  parameter int unsigned DATA_BITS    = 56,
  parameter int unsigned SYNC_FRAMES  = 16,
  parameter int unsigned LTNCY_PERIOD = 256
) (
  input logic                TRG_CLK80,
  input logic                TRG_RST_N,
  gem_trig_frame_tx_if.slave bus
);

  localparam int unsigned WcW = $clog2(FRAME_WORDS);
  localparam int unsigned ScW = (SYNC_FRAMES > 1) ? $clog2(SYNC_FRAMES) : 1;
  localparam int unsigned FcW = (LTNCY_PERIOD > 1) ? $clog2(LTNCY_PERIOD) : 1;
  localparam logic [WcW-1:0] WLast = WcW'(FRAME_WORDS - 1);
  localparam logic [ScW-1:0] SLast = ScW'(SYNC_FRAMES - 1);
  localparam logic [0:0] ST_SYNC = 1'b0;
  localparam logic [0:0] ST_DATA = 1'b1;
  localparam logic [31:0] COMMA   = 32'h50BC50BC;
  localparam logic [3:0]  COMMA_K = 4'b0101;

  if (DATA_BITS != 32 * FRAME_WORDS - 8) begin : gen_cfg_err
    $error("gem_trig_frame_tx: DATA_BITS must equal 32*FRAME_WORDS-8");
  end

  logic [WcW-1:0]              wcnt_q;
  logic [0:0]                  state_q;
  logic [ScW-1:0]              sync_cnt_q;
  logic [FcW-1:0]              fcnt_q;
  logic [1:0]                  rot_q;
  logic                        resync_pend_q;
  logic [NLINKS*DATA_BITS-1:0] hold_data_q;
  logic [NLINKS-1:0]           hold_ovf_q;
  logic                        hold_bc0_q;
  logic [1:0]                  hold_bxn_q;
  logic [NLINKS*32-1:0]        tx_data_q, tx_data_d;
  logic [NLINKS*4-1:0]         tx_isk_q, tx_isk_d;
  logic                        strobe_q, ready_q, ltncy_q;
  logic                        last_word, in_data;
  logic [NLINKS*DATA_BITS-1:0] cap_data;
  logic                        unused_bxn;

  assign last_word  = (wcnt_q == WLast);
  assign in_data    = (state_q == ST_DATA);
  assign unused_bxn = ^bus.BXN_COUNTER[11:2];

`ifdef GEM_TRIG_FRAME_PRBS_EN
  logic [30:0] lfsr_q [NLINKS];
  logic [30:0] lfsr_d [NLINKS];
  logic        inj_pend_q;

  // Payload source: LFSR advances at each DATA capture and the captured pattern uses the
  // advanced state; a pending error inject flips payload bit 0 on every lane.
  always_comb begin
    cap_data = bus.GEM_DATA;
    for (int i = 0; i < int'(NLINKS); i++) begin
      lfsr_d[i] = (last_word && in_data) ?
                  {lfsr_q[i][29:0], lfsr_q[i][30] ^ lfsr_q[i][27]} : lfsr_q[i];
      if (bus.ENA_TEST_PAT) begin
        cap_data[i*DATA_BITS +: DATA_BITS] = DATA_BITS'({lfsr_d[i], lfsr_d[i]});
      end
      if (inj_pend_q || bus.INJ_ERR) begin
        cap_data[i*DATA_BITS] = ~cap_data[i*DATA_BITS];
      end
    end
  end

  // LFSR state and one-shot error-inject request, consumed by the next capture.
  always_ff @(posedge TRG_CLK80 or negedge TRG_RST_N) begin
    if (!TRG_RST_N) begin
      for (int i = 0; i < int'(NLINKS); i++) lfsr_q[i] <= 31'(i + 1);
      inj_pend_q <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NLINKS); i++) lfsr_q[i] <= lfsr_d[i];
      if (last_word) inj_pend_q <= 1'b0;
      else if (bus.INJ_ERR) inj_pend_q <= 1'b1;
    end
  end
`else
  logic unused_test;
  assign cap_data    = bus.GEM_DATA;
  assign unused_test = ^{bus.ENA_TEST_PAT, bus.INJ_ERR};
`endif

  // Comma/resync sequencing; state changes only on the last word so frames never split.
  always_ff @(posedge TRG_CLK80 or negedge TRG_RST_N) begin
    if (!TRG_RST_N) begin
      state_q       <= ST_SYNC;
      sync_cnt_q    <= '0;
      resync_pend_q <= 1'b0;
    end else begin
      case (state_q)
        ST_SYNC: begin
          resync_pend_q <= 1'b0;
          if (bus.TX_RESYNC) begin
            sync_cnt_q <= '0;
          end else if (last_word) begin
            if (sync_cnt_q == SLast) begin
              state_q    <= ST_DATA;
              sync_cnt_q <= '0;
            end else begin
              sync_cnt_q <= sync_cnt_q + ScW'(1);
            end
          end
        end
        default: begin
          if (last_word && (resync_pend_q || bus.TX_RESYNC)) begin
            state_q       <= ST_SYNC;
            sync_cnt_q    <= '0;
            resync_pend_q <= 1'b0;
          end else if (bus.TX_RESYNC) begin
            resync_pend_q <= 1'b1;
          end
        end
      endcase
    end
  end

  // Word selection per lane: commas in SYNC, otherwise payload slices plus separator.
  always_comb begin
    logic [DATA_BITS-1:0] lane_sh;
    logic [1:0]           rot;
    logic [7:0]           sep;
    tx_data_d = '0;
    tx_isk_d  = '0;
    lane_sh   = '0;
    sep       = 8'hBC;
    rot       = bus.SEP_MODE ? hold_bxn_q : rot_q;
    for (int i = 0; i < int'(NLINKS); i++) begin
      lane_sh = hold_data_q[i*DATA_BITS +: DATA_BITS] << {wcnt_q, 5'd0};
      if (hold_ovf_q[i]) begin
        sep = 8'hFC;
      end else if (hold_bc0_q) begin
        sep = 8'h1C;
      end else begin
        case (rot)
          2'd0:    sep = 8'hBC;
          2'd1:    sep = 8'hF7;
          2'd2:    sep = 8'hFB;
          default: sep = 8'hFD;
        endcase
      end
      if (!in_data) begin
        tx_data_d[i*32 +: 32] = COMMA;
        tx_isk_d[i*4 +: 4]    = COMMA_K;
      end else if (last_word) begin
        tx_data_d[i*32 +: 32] = {hold_data_q[i*DATA_BITS +: 24], sep};
        tx_isk_d[i*4 +: 4]    = 4'b0001;
      end else begin
        tx_data_d[i*32 +: 32] = lane_sh[DATA_BITS-1 -: 32];
        tx_isk_d[i*4 +: 4]    = 4'b0000;
      end
    end
  end

  // Word counter, input capture, frame/rotation counters and registered outputs.
  always_ff @(posedge TRG_CLK80 or negedge TRG_RST_N) begin
    if (!TRG_RST_N) begin
      wcnt_q      <= '0;
      fcnt_q      <= '0;
      rot_q       <= '0;
      hold_data_q <= '0;
      hold_ovf_q  <= '0;
      hold_bc0_q  <= 1'b0;
      hold_bxn_q  <= '0;
      tx_data_q   <= {NLINKS{COMMA}};
      tx_isk_q    <= {NLINKS{COMMA_K}};
      strobe_q    <= 1'b0;
      ready_q     <= 1'b0;
      ltncy_q     <= 1'b0;
    end else begin
      wcnt_q <= last_word ? '0 : wcnt_q + WcW'(1);
      if (last_word) begin
        hold_data_q <= cap_data;
        hold_ovf_q  <= bus.GEM_OVERFLOW;
        hold_bc0_q  <= bus.BC0;
        hold_bxn_q  <= bus.BXN_COUNTER[1:0];
      end
      if (!in_data) begin
        rot_q  <= '0;
        fcnt_q <= '0;
      end else if (last_word) begin
        rot_q  <= rot_q + 2'd1;
        fcnt_q <= fcnt_q + FcW'(1);
      end
      tx_data_q <= tx_data_d;
      tx_isk_q  <= tx_isk_d;
      strobe_q  <= in_data && (wcnt_q == '0);
      ltncy_q   <= in_data && (wcnt_q == '0) && (LTNCY_PERIOD == 1 || fcnt_q == '0);
      ready_q   <= in_data;
    end
  end

  assign bus.TX_DATA      = tx_data_q;
  assign bus.TX_ISK       = tx_isk_q;
  assign bus.FRAME_STROBE = strobe_q;
  assign bus.LINK_READY   = ready_q;
  assign bus.LTNCY_TRIG   = ltncy_q;

endmodule
